spi_master_modport: RTL and testbench

SPI master byte engine behind the master-side testbench interface. Accepts one byte per `i_TX_DV` pulse, shifts it out MSB-first on MOSI while shifting in MISO, and returns the received byte with a one-cycle `o_RX_DV` pulse. It sits between on-chip logic (TX/RX byte handshake) and the external SPI pins. Chip select is not generated here; it is handled by the surrounding logic.

---
 rtl/spi_master_modport.sv | 134 +++++++++++++
 tb/tb_spi_master_modport.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_modport.sv
// SPI master byte engine: shifts one byte out on MOSI (MSB first) while
// shifting one byte in from MISO, then reports it with a one-cycle pulse.
//
// Ports:
//   i_Clk       system clock, all logic on its rising edge
//   i_Rst_L     synchronous reset, active HIGH (despite the name)
//   i_TX_Byte   byte to send, sampled with i_TX_DV
//   i_TX_DV     start pulse, honoured only while o_TX_Ready is high
//   o_TX_Ready  idle and able to take a new byte
//   o_RX_Byte   last complete received byte, held between transfers
//   o_RX_DV     one-cycle pulse when o_RX_Byte is refreshed
//   o_SPI_Clk   SPI clock, rests at CPOL
//   i_SPI_MISO  serial data in
//   o_SPI_MOSI  serial data out, holds its last value when idle
module spi_master_modport #(
    parameter int SPI_MODE          = 0,
    parameter int CLKS_PER_HALF_BIT = 2
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic [7:0] i_TX_Byte,
    input  logic       i_TX_DV,
    output logic       o_TX_Ready,
    output logic [7:0] o_RX_Byte,
    output logic       o_RX_DV,
    output logic       o_SPI_Clk,
    input  logic       i_SPI_MISO,
    output logic       o_SPI_MOSI
);

    localparam logic CPOL = (SPI_MODE == 2) || (SPI_MODE == 3);
    localparam logic CPHA = (SPI_MODE == 1) || (SPI_MODE == 3);
    localparam int   CW   = $clog2(2 * CLKS_PER_HALF_BIT);

    localparam logic [CW-1:0] LEAD_CNT  = CW'(CLKS_PER_HALF_BIT - 1);
    localparam logic [CW-1:0] TRAIL_CNT = CW'(2 * CLKS_PER_HALF_BIT - 1);

    logic          start;
    logic          start_d;
    logic [CW-1:0] half_cnt;
    logic [4:0]    edge_cnt;
    logic          lead;
    logic          trail;
    logic [7:0]    tx_byte;
    logic [2:0]    tx_bit;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_shift;

    // Requests arriving while busy are simply dropped.
    assign start = i_TX_DV && o_TX_Ready;

    // SPI clock generation. lead/trail are one-cycle flags that follow
    // each SPI clock toggle and drive the data shifters below.
    always_ff @(posedge i_Clk) begin
        if (i_Rst_L) begin
            o_TX_Ready <= 1'b0;
            edge_cnt   <= '0;
            half_cnt   <= '0;
            lead       <= 1'b0;
            trail      <= 1'b0;
            start_d    <= 1'b0;
            tx_byte    <= 8'h00;
            o_SPI_Clk  <= CPOL;
        end else begin
            lead    <= 1'b0;
            trail   <= 1'b0;
            start_d <= start;
            if (start) begin
                tx_byte    <= i_TX_Byte;
                edge_cnt   <= 5'd16;
                o_TX_Ready <= 1'b0;
            end else if (edge_cnt != 5'd0) begin
                o_TX_Ready <= 1'b0;
                if (half_cnt == TRAIL_CNT) begin
                    half_cnt  <= '0;
                    edge_cnt  <= edge_cnt - 5'd1;
                    trail     <= 1'b1;
                    o_SPI_Clk <= ~o_SPI_Clk;
                end else if (half_cnt == LEAD_CNT) begin
                    half_cnt  <= half_cnt + 1'b1;
                    edge_cnt  <= edge_cnt - 5'd1;
                    lead      <= 1'b1;
                    o_SPI_Clk <= ~o_SPI_Clk;
                end else begin
                    half_cnt <= half_cnt + 1'b1;
                end
            end else begin
                o_TX_Ready <= 1'b1;
            end
        end
    end

    // MOSI launch. With CPHA=0 bit 7 goes out ahead of the first edge and
    // the final trailing edge is skipped so MOSI keeps bit 0 when idle.
    always_ff @(posedge i_Clk) begin
        if (i_Rst_L) begin
            o_SPI_MOSI <= 1'b0;
            tx_bit     <= 3'd7;
        end else if (o_TX_Ready) begin
            tx_bit <= 3'd7;
        end else if (start_d && !CPHA) begin
            o_SPI_MOSI <= tx_byte[7];
            tx_bit     <= 3'd6;
        end else if ((lead && CPHA) ||
                     (trail && !CPHA && edge_cnt != 5'd0)) begin
            o_SPI_MOSI <= tx_byte[tx_bit];
            tx_bit     <= tx_bit - 3'd1;
        end
    end

    // MISO capture into a private shifter; the output byte only changes
    // once all eight bits are in.
    always_ff @(posedge i_Clk) begin
        if (i_Rst_L) begin
            rx_bit    <= 3'd7;
            rx_shift  <= 8'h00;
            o_RX_Byte <= 8'h00;
            o_RX_DV   <= 1'b0;
        end else begin
            o_RX_DV <= 1'b0;
            if (o_TX_Ready) begin
                rx_bit <= 3'd7;
            end else if ((lead && !CPHA) || (trail && CPHA)) begin
                rx_shift <= {rx_shift[6:0], i_SPI_MISO};
                rx_bit   <= rx_bit - 3'd1;
                if (rx_bit == 3'd0) begin
                    o_RX_Byte <= {rx_shift[6:0], i_SPI_MISO};
                    o_RX_DV   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_master_modport.sv
// Bench for spi_master_modport: one instance per SPI mode, a slave model
// on the pins and a scoreboard fed by the stimulus and drained on o_RX_DV.
module tb_spi_master_modport;

    localparam int HALF = 2;
    localparam int RISE_LO = 16 * HALF + 1;
    localparam int RISE_HI = 16 * HALF + 2;

    typedef struct {
        int         m;
        logic [7:0] rx;
        logic [7:0] tx;
    } exp_t;

    logic       clk;
    logic       rst     [4];
    logic [7:0] tx_byte [4];
    logic       tx_dv   [4];
    logic       ready   [4];
    logic [7:0] rx_byte [4];
    logic       rx_dv   [4];
    logic       sclk    [4];
    logic       miso    [4];
    logic       mosi    [4];

    // slave / monitor state
    logic       loopb  [4];
    logic [7:0] sl     [4];
    logic       sl_bit [4];
    logic [7:0] cap    [4];
    int         k      [4];
    int         rises  [4];
    bit         xfer   [4];
    bit         pready [4];
    bit         pclk   [4];
    bit         prxdv  [4];

    exp_t exp_q[$];
    exp_t mon_e;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_master_modport #(
            .SPI_MODE(g),
            .CLKS_PER_HALF_BIT(HALF)
        ) u_dut (
            .i_Clk(clk),
            .i_Rst_L(rst[g]),
            .i_TX_Byte(tx_byte[g]),
            .i_TX_DV(tx_dv[g]),
            .o_TX_Ready(ready[g]),
            .o_RX_Byte(rx_byte[g]),
            .o_RX_DV(rx_dv[g]),
            .o_SPI_Clk(sclk[g]),
            .i_SPI_MISO(miso[g]),
            .o_SPI_MOSI(mosi[g])
        );
        assign miso[g] = loopb[g] ? mosi[g] : sl_bit[g];
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic chk_rng(input string name, input int act,
                           input int lo, input int hi);
        total_cnt++;
        if (act >= lo && act <= hi) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d..%0d",
                      name, act, lo, hi);
    endtask

    task automatic chk_reset(input int m, input string tag);
        chk({tag, "_ready"}, ready[m], 0);
        chk({tag, "_rx_dv"}, rx_dv[m], 0);
        chk({tag, "_rx_byte"}, rx_byte[m], 0);
        chk({tag, "_sclk"}, sclk[m], (m >> 1) & 1);
        chk({tag, "_mosi"}, mosi[m], 0);
    endtask

    // Slave model and scoreboard monitor, sampled on the falling clock edge.
    always @(negedge clk) begin
        for (int m = 0; m < 4; m++) begin
            int bi;
            if (rst[m]) begin
                k[m]     = 0;
                rises[m] = 0;
                xfer[m]  = 0;
                pready[m] = 0;
                prxdv[m] = 0;
                pclk[m]  = sclk[m];
            end else begin
                if (sclk[m] !== pclk[m]) begin
                    k[m]++;
                    if (sclk[m]) rises[m]++;
                    if (k[m] == 1) cap[m] = 8'h00;
                    // CPHA=0 samples on odd (leading) edges, CPHA=1 on even
                    if ((k[m] % 2 == 1) != (m % 2 == 1))
                        cap[m] = {cap[m][6:0], mosi[m]};
                end
                pclk[m] = sclk[m];
                if (!ready[m] && pready[m]) xfer[m] = 1;
                if (ready[m] && !pready[m] && xfer[m]) begin
                    chk("edge_count", k[m], 16);
                    chk("rising_edges", rises[m], 8);
                    chk("idle_sclk", sclk[m], (m >> 1) & 1);
                    xfer[m]  = 0;
                    k[m]     = 0;
                    rises[m] = 0;
                end
                pready[m] = ready[m];
                if (prxdv[m]) chk("rx_dv_width", rx_dv[m], 0);
                if (rx_dv[m] && !prxdv[m]) begin
                    if (exp_q.size() == 0) begin
                        total_cnt++;
                        $display("FAIL rx_dv_unexpected: mode %0d byte %0h",
                                 m, rx_byte[m]);
                    end else begin
                        mon_e = exp_q.pop_front();
                        chk("rx_mode", m, mon_e.m);
                        chk("rx_byte", rx_byte[m], mon_e.rx);
                        chk("mosi_byte", cap[m], mon_e.tx);
                    end
                end
                prxdv[m] = rx_dv[m];
            end
            // slave launches bit 7 up front (CPHA=0) or on the first
            // leading edge (CPHA=1), then one bit per launch edge
            if (m % 2 == 1) bi = (k[m] == 0) ? 0 : (k[m] - 1) / 2;
            else bi = k[m] / 2;
            if (bi > 7) bi = 7;
            sl_bit[m] = sl[m][7 - bi];
        end
    end

    task automatic start_only(input int m, input logic [7:0] b,
                              input logic lp, input logic [7:0] sb,
                              input bit push);
        exp_t e;
        int n;
        n = 0;
        while (!ready[m] && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", ready[m], 1);
        loopb[m] = lp;
        sl[m] = sb;
        if (push) begin
            e.m = m;
            e.rx = lp ? b : sb;
            e.tx = b;
            exp_q.push_back(e);
        end
        tx_byte[m] = b;
        tx_dv[m] = 1'b1;
        @(negedge clk);
        tx_dv[m] = 1'b0;
        chk("ready_fall", ready[m], 0);
    endtask

    task automatic wait_done(input int m, input int n0);
        int n;
        n = n0;
        while (!ready[m] && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk_rng("ready_rise", n, RISE_LO, RISE_HI);
    endtask

    task automatic send(input int m, input logic [7:0] b,
                        input logic lp, input logic [7:0] sb);
        start_only(m, b, lp, sb, 1'b1);
        wait_done(m, 1);
    endtask

    initial begin
        int n;
        for (int m = 0; m < 4; m++) begin
            rst[m] = 1'b1;
            tx_dv[m] = 1'b0;
            tx_byte[m] = 8'h00;
            loopb[m] = 1'b1;
            sl[m] = 8'h00;
        end

        repeat (5) @(negedge clk);
        for (int m = 0; m < 4; m++) chk_reset(m, "reset");
        for (int m = 0; m < 4; m++) rst[m] = 1'b0;
        @(negedge clk);
        for (int m = 0; m < 4; m++) chk("ready_after_reset", ready[m], 1);

        // mode 0: loopback, slave pattern, ignored request, back-to-back
        send(0, 8'hA5, 1'b1, 8'h00);
        send(0, 8'hFF, 1'b0, 8'h3C);
        start_only(0, 8'h80, 1'b1, 8'h00, 1'b1);
        repeat (9) @(negedge clk);
        tx_byte[0] = 8'h11;
        tx_dv[0] = 1'b1;
        @(negedge clk);
        tx_dv[0] = 1'b0;
        wait_done(0, 11);
        send(0, 8'h01, 1'b1, 8'h00);
        send(0, 8'h02, 1'b1, 8'h00);
        send(0, 8'h03, 1'b1, 8'h00);

        // abort after four SPI edges: no pulse, outputs back to reset
        start_only(0, 8'hC3, 1'b1, 8'h00, 1'b0);
        n = 0;
        while (k[0] < 4 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk_rng("abort_edges_reached", k[0], 4, 5);
        rst[0] = 1'b1;
        @(negedge clk);
        chk_reset(0, "abort");
        @(negedge clk);
        rst[0] = 1'b0;
        @(negedge clk);
        chk("abort_ready", ready[0], 1);
        repeat (40) @(negedge clk);

        for (int m = 0; m < 4; m++) begin
            send(m, 8'h5A, 1'b1, 8'h00);
            send(m, 8'hFF, 1'b0, 8'h3C);
            for (int i = 0; i < 6; i++) begin
                send(m, 8'($urandom_range(0, 255)),
                     1'($urandom_range(0, 1)),
                     8'($urandom_range(0, 255)));
            end
        end

        repeat (10) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
